// File: rtl/si5340_i2c_target.sv
// si5340_i2c_target: I2C target emulating the Si5340 paged register interface.
// SCL/SDA are oversampled on clk; writes leave as strobes, reads are served
// through a one-cycle-latency read port, and SDA is open-drain via sda_oe.
module si5340_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b111_0100,
  parameter int unsigned HOLD_CYC   = 4,
  parameter logic [7:0]  PAGE_REG   = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  page,
  output logic        busy
);

  localparam int HOLD_W = (HOLD_CYC < 2) ? 2 : $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } state_t;

  // Synchronizer chains: [0],[1] resynchronize, [2] is the previous sample
  logic [2:0] scl_sr_q;
  logic [2:0] sda_sr_q;

  state_t            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              ack_ph_q;
  logic              rw_q;
  logic [7:0]        ptr_q;
  logic [7:0]        page_q;
  logic              busy_q;
  logic              wr_en_q;
  logic [15:0]       wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              rd_en_q;
  logic [15:0]       rd_addr_q;
  logic              rd_cap_q;
  logic [7:0]        tx_q;
  logic              pend_q;
  logic              pend_tx_q;
  logic              pend_val_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              sda_oe_q;

  logic       scl_rise;
  logic       scl_fall;
  logic       sda_bit;
  logic       start_ev;
  logic       stop_ev;
  logic [7:0] byte_d;
  logic       shift_state;
  logic       sched_en;
  logic       sched_tx;
  logic       sched_val;

  // Pad sampling into clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr_q <= 3'b111;
      sda_sr_q <= 3'b111;
    end else begin
      scl_sr_q <= {scl_sr_q[1:0], scl_i};
      sda_sr_q <= {sda_sr_q[1:0], sda_i};
    end
  end

  assign scl_rise = scl_sr_q[1] & ~scl_sr_q[2];
  assign scl_fall = ~scl_sr_q[1] & scl_sr_q[2];
  assign sda_bit  = sda_sr_q[1];
  // SCL must be high in both samples so a data change near an SCL edge is not mistaken
  assign start_ev = scl_sr_q[1] & scl_sr_q[2] & ~sda_sr_q[1] & sda_sr_q[2];
  assign stop_ev  = scl_sr_q[1] & scl_sr_q[2] & sda_sr_q[1] & ~sda_sr_q[2];
  assign byte_d   = {shift_q[6:0], sda_bit};
  assign shift_state = (state_q == ST_ADDR) || (state_q == ST_REG) || (state_q == ST_WDATA);

  // Decide on each SCL fall what SDA must become once the hold time has elapsed
  always_comb begin
    sched_en  = 1'b0;
    sched_tx  = 1'b0;
    sched_val = 1'b0;
    if (!stop_ev && !start_ev && scl_fall) begin
      case (state_q)
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          sched_en  = 1'b1;
          sched_val = ~ack_ph_q;
          sched_tx  = ack_ph_q && (state_q == ST_ADDR_ACK) && rw_q;
        end
        ST_RDATA: begin
          sched_en = 1'b1;
          sched_tx = 1'b1;
        end
        ST_RDATA_ACK: begin
          sched_en = 1'b1;
          sched_tx = ack_ph_q;
        end
        default: ;
      endcase
    end
  end

  // Protocol FSM: phase tracking, register pointer, page and the write/read ports
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      ack_ph_q  <= 1'b0;
      rw_q      <= 1'b0;
      ptr_q     <= 8'h00;
      page_q    <= 8'h00;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'h0000;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      if (stop_ev) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        ack_ph_q  <= 1'b0;
      end else if (start_ev) begin
        state_q   <= ST_ADDR;
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        ack_ph_q  <= 1'b0;
      end else begin
        if (scl_rise && shift_state) begin
          shift_q   <= byte_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        case (state_q)
          ST_ADDR: begin
            if (scl_rise && bit_cnt_q == 3'd7) begin
              if (byte_d[7:1] == SLAVE_ADDR) begin
                state_q <= ST_ADDR_ACK;
                busy_q  <= 1'b1;
                rw_q    <= byte_d[0];
              end else begin
                state_q <= ST_WAIT;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              ack_ph_q <= ~ack_ph_q;
              if (ack_ph_q) begin
                if (rw_q) begin
                  state_q   <= ST_RDATA;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {page_q, ptr_q};
                end else begin
                  state_q <= ST_REG;
                end
              end
            end
          end
          ST_REG: begin
            if (scl_rise && bit_cnt_q == 3'd7) begin
              ptr_q   <= byte_d;
              state_q <= ST_REG_ACK;
            end
          end
          ST_REG_ACK: begin
            if (scl_fall) begin
              ack_ph_q <= ~ack_ph_q;
              if (ack_ph_q) state_q <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (scl_rise && bit_cnt_q == 3'd7) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= {page_q, ptr_q};
              wr_data_q <= byte_d;
              if (ptr_q == PAGE_REG) page_q <= byte_d;
              state_q   <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            if (scl_fall) begin
              ack_ph_q <= ~ack_ph_q;
              if (ack_ph_q) begin
                ptr_q   <= ptr_q + 8'd1;
                state_q <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= ST_RDATA_ACK;
            end
          end
          ST_RDATA_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              ack_ph_q <= 1'b1;
            end else if (scl_rise && ack_ph_q && sda_bit) begin
              // Master NACK ends the read; the bus stays ours to ignore
              ack_ph_q <= 1'b0;
              state_q  <= ST_WAIT;
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q  <= 1'b0;
              ptr_q     <= ptr_q + 8'd1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= {page_q, ptr_q + 8'd1};
              state_q   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read byte: capture rd_data one cycle after rd_en, shift on each SCL fall while sending
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cap_q <= 1'b0;
    end else begin
      rd_cap_q <= rd_en_q;
    end
    if (rd_cap_q) begin
      tx_q <= rd_data;
    end else if (scl_fall && state_q == ST_RDATA && !start_ev && !stop_ev) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  // SDA driver: changes only HOLD_CYC cycles after the SCL fall that requested it
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_tx_q  <= 1'b0;
      pend_val_q <= 1'b0;
      hold_cnt_q <= '0;
      sda_oe_q   <= 1'b0;
    end else if (stop_ev || start_ev) begin
      pend_q   <= 1'b0;
      sda_oe_q <= 1'b0;
    end else if (sched_en) begin
      pend_q     <= 1'b1;
      pend_tx_q  <= sched_tx;
      pend_val_q <= sched_val;
      hold_cnt_q <= HOLD_LD;
    end else if (pend_q) begin
      if (hold_cnt_q == HOLD_W'(1)) begin
        pend_q <= 1'b0;
        // With HOLD_CYC==2 the read byte lands in this same cycle, so bypass it
        if (pend_tx_q) sda_oe_q <= ~(rd_cap_q ? rd_data[7] : tx_q[7]);
        else           sda_oe_q <= pend_val_q;
      end else begin
        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign page    = page_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Testbench for si5340_i2c_target: bit-banged I2C master, external register
// storage behind the write/read ports, and a transaction-level reference model.
module tb_si5340_i2c_target;

  localparam int         Q        = 10;
  localparam logic [7:0] PAGE_REG = 8'h01;
  localparam logic [7:0] AW       = 8'hE8;
  localparam logic [7:0] AR       = 8'hE9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  page;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Storage behind the DUT ports (written only by DUT writes)
  logic [7:0] regs    [0:65535];
  bit         written [0:65535];
  // Reference model state
  logic [7:0] mdl     [0:65535];
  bit         mw      [0:65535];
  logic [7:0] pg_m = 8'h00;
  logic [7:0] wbuf [0:3];

  // Port activity logs
  logic [23:0] wlog [0:255];
  logic [15:0] rlog [0:255];
  int wcnt = 0;
  int rcnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  si5340_i2c_target dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .page    (page),
    .busy    (busy)
  );

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mread(input logic [15:0] a);
    return mw[a] ? mdl[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= written[rd_addr] ? regs[rd_addr] : dflt(rd_addr);
      rlog[8'(rcnt)] <= rd_addr;
      rcnt <= rcnt + 1;
    end
    if (wr_en) begin
      regs[wr_addr]    <= wr_data;
      written[wr_addr] <= 1'b1;
      wlog[8'(wcnt)]   <= {wr_addr, wr_data};
      wcnt <= wcnt + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;  wq();
    scl_m = 1'b1; wq();
    s = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, nack);
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~ack, s);
  endtask

  task automatic do_write(input logic [7:0] r, input int n);
    logic nk;
    int base;
    logic [7:0] rr;
    logic [15:0] a;
    logic [23:0] ent;
    base = wcnt;
    i2c_start();
    wbyte(AW, nk); check("w_addr_ack", 32'(nk), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    wbyte(r, nk);  check("w_reg_ack", 32'(nk), 32'd0);
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], nk); check("w_data_ack", 32'(nk), 32'd0);
    end
    i2c_stop();
    wq();
    check("w_count", 32'(wcnt - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      rr  = r + 8'(i);
      a   = {pg_m, rr};
      ent = wlog[8'(base + i)];
      check("w_addr", 32'(ent[23:8]), 32'(a));
      check("w_data", 32'(ent[7:0]), 32'(wbuf[i]));
      mdl[a] = wbuf[i];
      mw[a]  = 1'b1;
      if (rr == PAGE_REG) pg_m = wbuf[i];
    end
    check("w_page", 32'(page), 32'(pg_m));
    check("w_busy_end", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] r, input int n);
    logic nk;
    int rbase, wbase;
    logic [7:0] d, rr;
    rbase = rcnt;
    wbase = wcnt;
    i2c_start();
    wbyte(AW, nk); check("r_addr_ack", 32'(nk), 32'd0);
    wbyte(r, nk);  check("r_reg_ack", 32'(nk), 32'd0);
    i2c_start();
    wbyte(AR, nk); check("r_raddr_ack", 32'(nk), 32'd0);
    check("r_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      rbyte(i < n - 1, d);
      rr = r + 8'(i);
      check("r_data", 32'(d), 32'(mread({pg_m, rr})));
    end
    check("r_released", 32'(sda_oe), 32'd0);
    i2c_stop();
    wq();
    check("r_count", 32'(rcnt - rbase), 32'(n));
    for (int i = 0; i < n; i++) begin
      rr = r + 8'(i);
      check("r_addr", 32'(rlog[8'(rbase + i)]), 32'({pg_m, rr}));
    end
    check("r_no_write", 32'(wcnt - wbase), 32'd0);
    check("r_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    logic nk;
    logic s;
    int base;
    logic [7:0] d;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_page", 32'(page), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    wq();

    // Write burst that also sets the page
    wbuf[0] = 8'h0A; wbuf[1] = 8'hB5;
    do_write(8'h01, 2);
    check("burst_page", 32'(page), 32'h0A);

    // Address mismatch, then a good address after repeated START
    base = wcnt;
    i2c_start();
    wbyte(8'hEA, nk); check("mm_addr_nack", 32'(nk), 32'd1);
    check("mm_busy", 32'(busy), 32'd0);
    wbyte(8'h10, nk); check("mm_data_nack", 32'(nk), 32'd1);
    i2c_start();
    wbyte(AW, nk); check("mm_good_ack", 32'(nk), 32'd0);
    check("mm_good_busy", 32'(busy), 32'd1);
    i2c_stop();
    wq();
    check("mm_no_write", 32'(wcnt - base), 32'd0);
    check("mm_busy_end", 32'(busy), 32'd0);

    // Page 5, seed 0x0520.. then read them back with ACK,ACK,NACK
    wbuf[0] = 8'h05;
    do_write(8'h01, 1);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(8'h20, 3);
    do_read(8'h20, 3);

    // Pointer wrap: page must not change
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(8'hFF, 2);
    check("wrap_page", 32'(page), 32'h05);

    // STOP after 4 bits of a data byte
    base = wcnt;
    i2c_start();
    wbyte(AW, nk);    check("ab_addr_ack", 32'(nk), 32'd0);
    wbyte(8'h30, nk); check("ab_reg_ack", 32'(nk), 32'd0);
    for (int i = 0; i < 4; i++) clk_bit(i[0], s);
    i2c_stop();
    wq();
    check("ab_no_write", 32'(wcnt - base), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);

    // Repeated START mid-data: pointer 0x40 kept for the following read
    base = rcnt;
    i2c_start();
    wbyte(AW, nk);    check("sr_addr_ack", 32'(nk), 32'd0);
    wbyte(8'h40, nk); check("sr_reg_ack", 32'(nk), 32'd0);
    for (int i = 0; i < 3; i++) clk_bit(~i[0], s);
    i2c_start();
    wbyte(AR, nk);    check("sr_raddr_ack", 32'(nk), 32'd0);
    rbyte(1'b0, d);
    check("sr_data", 32'(d), 32'(mread({pg_m, 8'h40})));
    i2c_stop();
    wq();
    check("sr_rd_count", 32'(rcnt - base), 32'd1);
    check("sr_rd_addr", 32'(rlog[8'(base)]), 32'({pg_m, 8'h40}));

    // Reset while the target is pulling SDA low in a read
    wbuf[0] = 8'h3C;
    do_write(8'h50, 1);
    i2c_start();
    wbyte(AW, nk);    check("rr_addr_ack", 32'(nk), 32'd0);
    wbyte(8'h50, nk); check("rr_reg_ack", 32'(nk), 32'd0);
    i2c_start();
    wbyte(AR, nk);    check("rr_raddr_ack", 32'(nk), 32'd0);
    check("rr_driving", 32'(sda_oe), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rr_sda_oe", 32'(sda_oe), 32'd0);
    check("rr_wr_en", 32'(wr_en), 32'd0);
    check("rr_rd_en", 32'(rd_en), 32'd0);
    check("rr_wr_addr", 32'(wr_addr), 32'd0);
    check("rr_wr_data", 32'(wr_data), 32'd0);
    check("rr_rd_addr", 32'(rd_addr), 32'd0);
    check("rr_page", 32'(page), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    pg_m = 8'h00;
    wbuf[0] = 8'hAB;
    do_write(8'h60, 1);

    // Randomized write/read bursts against the model
    for (int t = 0; t < 8; t++) begin
      logic [7:0] r;
      int n;
      r = 8'($urandom);
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(r, n);
      else                           do_read(r, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
